sdpram_fifo_ctrl: RTL and testbench
===================================

// Module: sdpram_fifo_ctrl
// PURPOSE
//  First-word-fall-through FIFO controller that sequences one external simple dual port RAM.
//  The RAM interface is sdpram_if, sdp_m side, with BYTE_WRITE=0.
//  Turns the RAM's raw write port (a) and read port (b) into valid/ready stream ports.
//  Manages wrap-around pointers, occupancy and the RAM's 1-cycle read latency.
//  Sits between a producer and a consumer in front of any simple_dual_port_ram instance.
// PARAMETERS
//  DATA_WIDTH  32    word width; must match the RAM
//  MEM_DEPTH   1024  RAM depth in words; power of 2, >=4
//  ADDR_WIDTH  $clog2(MEM_DEPTH)    localparam
//  LVL_WIDTH   $clog2(MEM_DEPTH+3)  localparam
// PORTS
//  clk        in   1           single clock, all logic rising-edge
//  rst        in   1           asynchronous reset, active-high
//  flush      in   1           synchronous clear of all contents
//  s_valid    in   1           producer word valid
//  s_ready    out  1           controller can accept a word
//  s_data     in   DATA_WIDTH  producer word
//  m_valid    out  1           head word valid
//  m_ready    in   1           consumer takes head word
//  m_data     out  DATA_WIDTH  head word
//  level      out  LVL_WIDTH   total words held (RAM + output buffer)
//  ram_addra  out  ADDR_WIDTH  RAM write address
//  ram_wena   out  1           RAM write enable
//  ram_dina   out  DATA_WIDTH  RAM write data
//  ram_addrb  out  ADDR_WIDTH  RAM read address
//  ram_renb   out  1           RAM read enable
//  ram_doutb  in   DATA_WIDTH  RAM read data
//  ram_dvalb  in   1           RAM read data valid, 1 cycle after ram_renb
// BEHAVIOUR
//  Reset (rst=1, async): wptr=rptr=0, ram_cnt=0, output buffer empty, in-flight flag 0.
//   Outputs during reset: s_ready=0, m_valid=0, level=0, ram_wena=0, ram_renb=0,
//   ram_addra=0, ram_addrb=0, m_data=0.
//  Write side:
//   s_ready = (ram_cnt != MEM_DEPTH) & ~flush.
//   On s_valid&s_ready, combinationally in the same cycle: ram_wena=1, ram_addra=wptr,
//    ram_dina=s_data. At the clock edge, wptr increments.
//  Read side:
//   Output buffer is 2 entries (head + skid) so full throughput survives the read latency.
//   Issue condition: ram_renb=1 and ram_addrb=rptr when ram_cnt>0 (registered count) and
//    (buffered entries + in-flight) < 2, considering a head pop in the same cycle.
//   At the issue edge, rptr increments and the in-flight flag is set.
//   ram_doutb is captured when ram_dvalb=1 into head if it is empty/popping, else into skid.
//   m_valid = head occupied; m_data = head word.
//   On a pop (m_valid&m_ready), skid moves into head.
//  Pointers wrap from MEM_DEPTH-1 to 0 naturally (ADDR_WIDTH bits).
//  ram_cnt next value = ram_cnt + write - issue; simultaneous write and issue leaves it unchanged.
//  A word written at edge N is readable by an issue no earlier than cycle N+1.
//   No same-cycle read of the address being written.
//  level = ram_cnt + in-flight + buffered entries; updated registered, max MEM_DEPTH+2.
//  Minimum latency from write to m_valid on an empty FIFO: 3 cycles (write, issue, capture).
//  Full: s_ready=0; s_valid is ignored with no wptr change and no RAM write.
//  Empty: no issue; m_valid=0; m_ready is ignored.
//  flush=1: next edge clears pointers, count and buffer.
//   A ram_dvalb arriving the cycle after the flush is discarded.
//   s_ready=0 and ram_wena=0 while flush=1.
//  Async reset mid-operation: immediate return to reset state; data is lost and
//   any in-flight read is discarded.
//  ram_dvalb without an outstanding issue: ignored.
// TESTING
//  T1 reset: rst=1 mid-stream -> all outputs 0 immediately; after release, s_ready=1 on the next cycle, level=0.
//  T2 latency: write 0x55 at cycle 0 into empty -> ram_wena=1, ram_addra=0 at cycle 0;
//   ram_renb=1, ram_addrb=0 at cycle 1; m_valid=1, m_data=0x55 at cycle 3.
//  T3 full: write 1024 words 0..1023 with m_ready=0 -> after the 1024th word plus 2 prefetched,
//   accept 2 more, then s_ready=0 at level=1026; extra s_valid causes no RAM write.
//  T4 wrap/throughput: s_valid=m_ready=1 continuously for 3000 words of an incrementing pattern ->
//   output in order; after fill, one word per cycle; ram_addra wraps 1023->0.
//  T5 backpressure: random m_ready at 50% with 200 words -> no loss or duplication;
//   m_data stable while m_valid&~m_ready.
//  T6 flush: 10 words stored plus a read in flight, pulse flush -> next cycle m_valid=0, level=0;
//   the stale ram_dvalb is dropped; a new word 0xA5 emerges as the head.

Source files
------------

// File: rtl/sdpram_fifo_ctrl_if.sv
// Stream and RAM-port bundle for the FWFT FIFO controller.
// master: the controller's view; slave: the producer/consumer/RAM environment.
interface sdpram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
);
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);
    localparam int LVL_WIDTH  = $clog2(MEM_DEPTH + 3);

    logic                  flush;
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [LVL_WIDTH-1:0]  level;
    logic [ADDR_WIDTH-1:0] ram_addra;
    logic                  ram_wena;
    logic [DATA_WIDTH-1:0] ram_dina;
    logic [ADDR_WIDTH-1:0] ram_addrb;
    logic                  ram_renb;
    logic [DATA_WIDTH-1:0] ram_doutb;
    logic                  ram_dvalb;

    modport master (
        input  flush, s_valid, s_data, m_ready, ram_doutb, ram_dvalb,
        output s_ready, m_valid, m_data, level,
               ram_addra, ram_wena, ram_dina, ram_addrb, ram_renb
    );

    modport slave (
        output flush, s_valid, s_data, m_ready, ram_doutb, ram_dvalb,
        input  s_ready, m_valid, m_data, level,
               ram_addra, ram_wena, ram_dina, ram_addrb, ram_renb
    );
endinterface

// File: rtl/sdpram_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving an external simple dual port RAM.
// A two-entry output buffer (head + skid) hides the RAM's 1-cycle read latency.
module sdpram_fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic               clk,
    input  logic               rst,
    sdpram_fifo_ctrl_if.master bus
);
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);
    localparam int LVL_WIDTH  = $clog2(MEM_DEPTH + 3);
    localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(MEM_DEPTH);

    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH:0]   r_ram_cnt;
    logic                  r_inflight;
    logic                  r_head_v;
    logic                  r_skid_v;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_skid;
    logic [LVL_WIDTH-1:0]  r_level;

    logic                  w_s_ready;
    logic                  w_write;
    logic                  w_pop;
    logic                  w_capture;
    logic [1:0]            w_buf_cnt;
    logic [2:0]            w_occ;
    logic                  w_issue;
    logic [ADDR_WIDTH:0]   w_cnt_next;
    logic                  w_head_v_next;
    logic                  w_skid_v_next;
    logic [DATA_WIDTH-1:0] w_head_next;
    logic [DATA_WIDTH-1:0] w_skid_next;
    logic [LVL_WIDTH-1:0]  w_level_next;

    // Handshakes. Reset and flush both close the write side; reads are only issued
    // for words already counted in the RAM and only when the buffer will have room
    // for the returning word, counting the head pop of this same cycle.
    assign w_s_ready = ~rst & ~bus.flush & (r_ram_cnt != CNT_FULL);
    assign w_write   = bus.s_valid & w_s_ready;
    assign w_pop     = r_head_v & bus.m_ready;
    assign w_capture = bus.ram_dvalb & r_inflight;
    assign w_buf_cnt = {1'b0, r_head_v} + {1'b0, r_skid_v};
    assign w_occ     = {1'b0, w_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue   = ~rst & ~bus.flush & (r_ram_cnt != '0) & (w_occ < 3'd2);

    assign bus.s_ready   = w_s_ready;
    assign bus.ram_wena  = w_write;
    assign bus.ram_addra = r_wptr;
    assign bus.ram_dina  = bus.s_data;
    assign bus.ram_renb  = w_issue;
    assign bus.ram_addrb = r_rptr;
    assign bus.m_valid   = r_head_v;
    assign bus.m_data    = r_head;
    assign bus.level     = r_level;

    // Next RAM occupancy: a write and an issue in the same cycle cancel out.
    always_comb begin
        w_cnt_next = r_ram_cnt;
        case ({w_write, w_issue})
            2'b10:   w_cnt_next = r_ram_cnt + (ADDR_WIDTH+1)'(1);
            2'b01:   w_cnt_next = r_ram_cnt - (ADDR_WIDTH+1)'(1);
            default: w_cnt_next = r_ram_cnt;
        endcase
    end

    // Output buffer: a pop shifts skid into head; returning RAM data lands in the
    // first free slot after that shift.
    always_comb begin
        w_head_next   = r_head;
        w_skid_next   = r_skid;
        w_head_v_next = r_head_v;
        w_skid_v_next = r_skid_v;
        if (w_pop) begin
            if (r_skid_v) begin
                w_head_next = r_skid;
                if (w_capture) begin
                    w_skid_next = bus.ram_doutb;
                end else begin
                    w_skid_v_next = 1'b0;
                end
            end else begin
                if (w_capture) begin
                    w_head_next = bus.ram_doutb;
                end else begin
                    w_head_v_next = 1'b0;
                end
            end
        end else if (w_capture) begin
            if (!r_head_v) begin
                w_head_next   = bus.ram_doutb;
                w_head_v_next = 1'b1;
            end else begin
                w_skid_next   = bus.ram_doutb;
                w_skid_v_next = 1'b1;
            end
        end
        w_level_next = LVL_WIDTH'(w_cnt_next) + LVL_WIDTH'(w_issue)
                     + LVL_WIDTH'(w_head_v_next) + LVL_WIDTH'(w_skid_v_next);
    end

    // State update; flush wins over everything so a read returning during it is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_ram_cnt  <= '0;
            r_inflight <= 1'b0;
            r_head_v   <= 1'b0;
            r_skid_v   <= 1'b0;
            r_head     <= '0;
            r_skid     <= '0;
            r_level    <= '0;
        end else if (bus.flush) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_ram_cnt  <= '0;
            r_inflight <= 1'b0;
            r_head_v   <= 1'b0;
            r_skid_v   <= 1'b0;
            r_level    <= '0;
        end else begin
            if (w_write) begin
                r_wptr <= r_wptr + ADDR_WIDTH'(1);
            end
            if (w_issue) begin
                r_rptr <= r_rptr + ADDR_WIDTH'(1);
            end
            r_ram_cnt  <= w_cnt_next;
            r_inflight <= w_issue;
            r_head_v   <= w_head_v_next;
            r_skid_v   <= w_skid_v_next;
            r_head     <= w_head_next;
            r_skid     <= w_skid_next;
            r_level    <= w_level_next;
        end
    end
endmodule

// File: tb/tb_sdpram_fifo_ctrl.sv
// Directed testbench for sdpram_fifo_ctrl with a behavioural 1-cycle-latency RAM.
module tb_sdpram_fifo_ctrl;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sdpram_fifo_ctrl_if #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) bus ();

    sdpram_fifo_ctrl #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Behavioural RAM: write on the edge, read data and valid one cycle after renb.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_wena) mem[bus.ram_addra] <= bus.ram_dina;
        if (bus.ram_renb) bus.ram_doutb <= mem[bus.ram_addrb];
        bus.ram_dvalb <= bus.ram_renb;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives one cycle's inputs just after the rising edge and returns mid-cycle for sampling.
    task automatic applyStimulus(input logic sv, input logic [31:0] sd, input logic mr, input logic fl);
        @(posedge clk);
        #1;
        bus.s_valid = sv;
        bus.s_data  = sd;
        bus.m_ready = mr;
        bus.flush   = fl;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int accepted, expIdx, sent, recv, wraps, gaps, cyc;
        logic [9:0] prevAddr;
        logic havePrev, prevStall, mr;
        logic [31:0] prevData;

        rst = 1'b1;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0; bus.flush = 1'b0;
        #2;
        checkOutput("rst s_ready", 32'(bus.s_ready), 0);
        checkOutput("rst level",   32'(bus.level), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // T1: reset in the middle of a stream
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h100 + i, 1'b0, 1'b0);
        checkOutput("T1 pre m_valid", 32'(bus.m_valid), 1);
        @(posedge clk);
        #1 bus.s_valid = 1'b1;
        #1 rst = 1'b1;
        #1;
        checkOutput("T1 s_ready",   32'(bus.s_ready), 0);
        checkOutput("T1 m_valid",   32'(bus.m_valid), 0);
        checkOutput("T1 level",     32'(bus.level), 0);
        checkOutput("T1 ram_wena",  32'(bus.ram_wena), 0);
        checkOutput("T1 ram_renb",  32'(bus.ram_renb), 0);
        checkOutput("T1 ram_addra", 32'(bus.ram_addra), 0);
        checkOutput("T1 ram_addrb", 32'(bus.ram_addrb), 0);
        checkOutput("T1 m_data",    32'(bus.m_data), 0);
        bus.s_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        checkOutput("T1 rel s_ready", 32'(bus.s_ready), 1);
        checkOutput("T1 rel level",   32'(bus.level), 0);
        checkOutput("T1 rel m_valid", 32'(bus.m_valid), 0);

        // T2: write-to-head latency on an empty FIFO
        applyStimulus(1'b1, 32'h55, 1'b0, 1'b0);
        checkOutput("T2 c0 ram_wena",  32'(bus.ram_wena), 1);
        checkOutput("T2 c0 ram_addra", 32'(bus.ram_addra), 0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        checkOutput("T2 c1 ram_renb",  32'(bus.ram_renb), 1);
        checkOutput("T2 c1 ram_addrb", 32'(bus.ram_addrb), 0);
        checkOutput("T2 c1 level",     32'(bus.level), 1);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        checkOutput("T2 c2 m_valid",   32'(bus.m_valid), 0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        checkOutput("T2 c3 m_valid",   32'(bus.m_valid), 1);
        checkOutput("T2 c3 m_data",    bus.m_data, 32'h55);
        checkOutput("T2 c3 level",     32'(bus.level), 1);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        checkOutput("T2 empty m_valid", 32'(bus.m_valid), 0);
        checkOutput("T2 empty level",   32'(bus.level), 0);

        // T3: fill to DEPTH+2 with the consumer stalled, then drain in order
        accepted = 0;
        cyc = 0;
        while (accepted < DEPTH + 2 && cyc < 3000) begin
            applyStimulus(1'b1, 32'(accepted), 1'b0, 1'b0);
            if (bus.s_ready) accepted++;
            cyc++;
        end
        checkOutput("T3 accepted", 32'(accepted), DEPTH + 2);
        applyStimulus(1'b1, 32'hDEAD, 1'b0, 1'b0);
        checkOutput("T3 full s_ready",  32'(bus.s_ready), 0);
        checkOutput("T3 full ram_wena", 32'(bus.ram_wena), 0);
        checkOutput("T3 full level",    32'(bus.level), DEPTH + 2);
        expIdx = 0;
        cyc = 0;
        while (expIdx < DEPTH + 2 && cyc < 3000) begin
            applyStimulus(1'b0, 0, 1'b1, 1'b0);
            if (bus.m_valid) begin
                checkOutput("T3 drain data", bus.m_data, 32'(expIdx));
                expIdx++;
            end
            cyc++;
        end
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        checkOutput("T3 drained count", 32'(expIdx), DEPTH + 2);
        checkOutput("T3 drained level", 32'(bus.level), 0);

        // T4: continuous streaming, address wrap and one word per cycle
        sent = 0; recv = 0; wraps = 0; gaps = 0; cyc = 0;
        havePrev = 1'b0; prevAddr = '0;
        while (recv < 3000 && cyc < 10000) begin
            applyStimulus(sent < 3000, 32'h1000 + sent, 1'b1, 1'b0);
            if (bus.ram_wena) begin
                if (havePrev && prevAddr == 10'd1023 && bus.ram_addra == 10'd0) wraps++;
                prevAddr = bus.ram_addra;
                havePrev = 1'b1;
            end
            if (bus.s_valid && bus.s_ready) sent++;
            if (bus.m_valid) begin
                checkOutput("T4 data", bus.m_data, 32'h1000 + recv);
                recv++;
            end else if (recv > 0) begin
                gaps++;
            end
            cyc++;
        end
        checkOutput("T4 received", 32'(recv), 3000);
        checkOutput("T4 gaps", 32'(gaps), 0);
        checkOutput("T4 wraps", 32'(wraps), 2);

        // T5: random consumer backpressure
        sent = 0; recv = 0; cyc = 0;
        prevStall = 1'b0; prevData = '0;
        while (recv < 200 && cyc < 5000) begin
            mr = 1'($urandom_range(0, 1));
            applyStimulus(sent < 200, 32'h2000 + sent, mr, 1'b0);
            if (prevStall) begin
                checkOutput("T5 hold valid", 32'(bus.m_valid), 1);
                checkOutput("T5 hold data", bus.m_data, prevData);
            end
            if (bus.s_valid && bus.s_ready) sent++;
            if (bus.m_valid && bus.m_ready) begin
                checkOutput("T5 data", bus.m_data, 32'h2000 + recv);
                recv++;
            end
            prevStall = bus.m_valid & ~bus.m_ready;
            prevData  = bus.m_data;
            cyc++;
        end
        checkOutput("T5 received", 32'(recv), 200);
        repeat (3) applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkOutput("T5 no extra m_valid", 32'(bus.m_valid), 0);
        checkOutput("T5 final level", 32'(bus.level), 0);

        // T6: flush with a read in flight
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 32'h3000 + i, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 0, 1'b0, 1'b0);
        checkOutput("T6 level 10", 32'(bus.level), 10);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkOutput("T6 issue on pop", 32'(bus.ram_renb), 1);
        applyStimulus(1'b1, 32'hBAD, 1'b0, 1'b1);
        checkOutput("T6 flush s_ready",  32'(bus.s_ready), 0);
        checkOutput("T6 flush ram_wena", 32'(bus.ram_wena), 0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        checkOutput("T6 after m_valid", 32'(bus.m_valid), 0);
        checkOutput("T6 after level",   32'(bus.level), 0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        checkOutput("T6 stale dropped", 32'(bus.m_valid), 0);
        applyStimulus(1'b1, 32'hA5, 1'b0, 1'b0);
        checkOutput("T6 new ram_addra", 32'(bus.ram_addra), 0);
        repeat (3) applyStimulus(1'b0, 0, 1'b0, 1'b0);
        checkOutput("T6 new m_valid", 32'(bus.m_valid), 1);
        checkOutput("T6 new m_data",  bus.m_data, 32'hA5);
        checkOutput("T6 new level",   32'(bus.level), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
